chain_timing_ctrl: RTL
======================

CHAIN_TIMING_CTRL -- requirements
Module: chain_timing_ctrl

Interface
REQ-001 Parameter OVERSAMP, 4, oversampling factor; SHALL be a power of two and at least 2.
REQ-002 Parameter NB_PHASE, 2, width of phase counter; SHALL equal log2(OVERSAMP).
REQ-003 Parameter FLUSH_CYCLES, 17, flush duration in clocks (FIR tap count); SHALL be in 1..255.
REQ-004 Parameter WARMUP_SYMS, 6, warm-up duration in symbols (tx filter NBAUD); SHALL be in 1..255.
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 i_reset  in  1  reset, asynchronous, active-high.
REQ-007 i_enable  in  1  run request; level-sensitive.
REQ-008 i_dw_offset  in  1  rate-2 decimation phase select (0 or 1).
REQ-009 o_counter  out  NB_PHASE  polyphase phase select.
REQ-010 o_count_max  out  1  rate-1 (symbol) strobe.
REQ-011 o_count_half_or_max  out  1  rate-2 (OVERSAMP/2) strobe.
REQ-012 o_flush  out  1  datapath clear request to filters/downsamplers.
REQ-013 o_valid_r2  out  1  rate-2 sample valid for the equalizer input.
REQ-014 o_state  out  2  current FSM state code.

Function
REQ-015 FSM states SHALL be IDLE=0, FLUSH=1, WARMUP=2, RUN=3, with registered state.
REQ-016 IDLE: o_counter=0, o_flush=1, all strobes 0; i_enable=1 at an edge SHALL move to FLUSH.
REQ-017 FLUSH: o_counter held 0, o_flush=1, strobes 0; state SHALL last exactly FLUSH_CYCLES clocks, then WARMUP.
REQ-018 i_dw_offset SHALL be latched only on the FLUSH->WARMUP edge; changes at other times SHALL be ignored until the next flush.
REQ-019 WARMUP and RUN: o_flush=0; o_counter SHALL be 0 in the first WARMUP cycle and increment by 1 per clock, wrapping OVERSAMP-1 -> 0.
REQ-020 o_count_max SHALL be 1 iff state is WARMUP or RUN and o_counter==OVERSAMP-1 (combinational decode of registered values).
REQ-021 o_count_half_or_max SHALL be 1 iff state is WARMUP or RUN and ((o_counter + latched offset) mod (OVERSAMP/2)) == OVERSAMP/2-1.
REQ-022 WARMUP SHALL count o_count_max pulses; on the clock where the WARMUP_SYMS-th pulse is asserted the next state SHALL be RUN, so WARMUP lasts WARMUP_SYMS*OVERSAMP clocks.
REQ-023 o_valid_r2 SHALL equal o_count_half_or_max in RUN and 0 in all other states.
REQ-024 RUN SHALL persist with o_counter free-running and no phase slip while i_enable=1.
REQ-025 i_enable=0 at an edge in FLUSH, WARMUP or RUN SHALL move to IDLE next cycle, clearing o_counter, flush and warm-up counters; no partial-sequence resume.
REQ-026 i_enable=1 held in IDLE after abort SHALL restart a full FLUSH of FLUSH_CYCLES clocks.
REQ-027 o_state SHALL reflect the registered state code with zero latency.

Reset
REQ-028 i_reset=1 SHALL immediately force state=IDLE, o_counter=0, flush/warm-up counters=0, latched offset=0, regardless of clk.
REQ-029 During and on release of reset, outputs SHALL be o_flush=1, o_count_max=0, o_count_half_or_max=0, o_valid_r2=0, o_state=0; first transition SHALL require i_enable=1 at a clock edge after release.
REQ-030 Reset asserted mid-RUN SHALL discard all sequencing state; no strobe SHALL appear while reset is high.

Verification (defaults OVERSAMP=4, FLUSH_CYCLES=17, WARMUP_SYMS=6)
REQ-031 Reset release, i_enable=1 from edge 0 -> FLUSH edges 1-17 (o_flush=1), WARMUP edges 18-41, RUN from edge 42, first o_valid_r2 within edge 42-45.
REQ-032 RUN, offset=0 -> o_counter 0,1,2,3,0..; o_count_max on counter=3; o_count_half_or_max on counter=1,3; o_valid_r2 identical to rate-2 strobe.
REQ-033 Offset=1 latched at FLUSH->WARMUP -> rate-2 strobe on counter=0,2; toggling i_dw_offset during RUN -> strobe positions unchanged.
REQ-034 i_enable dropped at WARMUP cycle 10 -> IDLE next edge, o_counter=0, o_flush=1; re-enable -> full 17-cycle FLUSH again.
REQ-035 Async i_reset pulse between edges during RUN -> outputs at reset values before next edge; o_state=0.
REQ-036 FLUSH_CYCLES=1, WARMUP_SYMS=1 -> FLUSH one clock, WARMUP four clocks, RUN on sixth edge after enable.

Source files
------------

// File: rtl/chain_timing_ctrl.sv
// Timing sequencer for a polyphase tx/rx filter chain: holds the datapath in flush,
// runs a symbol-counted warm-up, then free-runs the phase counter and rate strobes.
module chain_timing_ctrl #(
  parameter int OVERSAMP     = 4,
  parameter int NB_PHASE     = 2,
  parameter int FLUSH_CYCLES = 17,
  parameter int WARMUP_SYMS  = 6
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_dw_offset,
  output logic [NB_PHASE-1:0] o_counter,
  output logic                o_count_max,
  output logic                o_count_half_or_max,
  output logic                o_flush,
  output logic                o_valid_r2,
  output logic [1:0]          o_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    WARMUP = 2'd2,
    RUN    = 2'd3
  } state_e;

  localparam logic [NB_PHASE-1:0] CNT_MAX    = NB_PHASE'(OVERSAMP - 1);
  localparam logic [NB_PHASE:0]   HALF_MASK  = (NB_PHASE + 1)'(OVERSAMP / 2 - 1);
  localparam logic [7:0]          FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0]          WARM_LAST  = 8'(WARMUP_SYMS - 1);

  state_e                state_q, state_d;
  logic [NB_PHASE-1:0]   counter_q, counter_d;
  logic [7:0]            flush_cnt_q, flush_cnt_d;
  logic [7:0]            sym_cnt_q, sym_cnt_d;
  logic                  offset_q, offset_d;

  logic                  active;
  logic                  count_max;
  logic                  half_hit;
  logic [NB_PHASE:0]     phase_sum;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      flush_cnt_q <= '0;
      sym_cnt_q   <= '0;
      offset_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      counter_q   <= counter_d;
      flush_cnt_q <= flush_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      offset_q    <= offset_d;
    end
  end

  // Strobes are pure decodes of registered state so they never glitch across phases.
  assign active    = (state_q == WARMUP) || (state_q == RUN);
  assign count_max = active && (counter_q == CNT_MAX);
  assign phase_sum = {1'b0, counter_q} + {{NB_PHASE{1'b0}}, offset_q};
  assign half_hit  = active && ((phase_sum & HALF_MASK) == HALF_MASK);

  always_comb begin
    state_d     = state_q;
    counter_d   = counter_q;
    flush_cnt_d = flush_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    offset_d    = offset_q;
    case (state_q)
      IDLE: begin
        counter_d   = '0;
        flush_cnt_d = '0;
        sym_cnt_d   = '0;
        if (i_enable) state_d = FLUSH;
      end
      FLUSH: begin
        counter_d = '0;
        if (!i_enable) begin
          state_d     = IDLE;
          flush_cnt_d = '0;
          sym_cnt_d   = '0;
        end else if (flush_cnt_q == FLUSH_LAST) begin
          // The decimation phase is only sampled here so it cannot slip mid-run.
          state_d     = WARMUP;
          flush_cnt_d = '0;
          sym_cnt_d   = '0;
          offset_d    = i_dw_offset;
        end else begin
          flush_cnt_d = flush_cnt_q + 8'd1;
        end
      end
      WARMUP: begin
        if (!i_enable) begin
          state_d     = IDLE;
          counter_d   = '0;
          flush_cnt_d = '0;
          sym_cnt_d   = '0;
        end else begin
          counter_d = counter_q + 1'b1;
          if (count_max) begin
            if (sym_cnt_q == WARM_LAST) begin
              state_d   = RUN;
              sym_cnt_d = '0;
            end else begin
              sym_cnt_d = sym_cnt_q + 8'd1;
            end
          end
        end
      end
      RUN: begin
        if (!i_enable) begin
          state_d     = IDLE;
          counter_d   = '0;
          flush_cnt_d = '0;
          sym_cnt_d   = '0;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = '0;
      end
    endcase
  end

  assign o_counter           = counter_q;
  assign o_count_max         = count_max;
  assign o_count_half_or_max = half_hit;
  assign o_flush             = (state_q == IDLE) || (state_q == FLUSH);
  assign o_valid_r2          = (state_q == RUN) && half_hit;
  assign o_state             = state_q;

endmodule
